// File: rtl/maze_cell_arbiter_if.sv
// maze_cell_arbiter_if: carver/display request ports plus the single-port cell RAM port.
interface maze_cell_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int CELL_W = 2
);
  logic              carv_req;
  logic              carv_we;
  logic              carv_lock;
  logic [ADDR_W-1:0] carv_addr;
  logic [CELL_W-1:0] carv_wdata;
  logic              carv_gnt;
  logic              carv_rvalid;
  logic [CELL_W-1:0] carv_rdata;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [CELL_W-1:0] disp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [CELL_W-1:0] mem_wdata;
  logic [CELL_W-1:0] mem_rdata;
  modport slave (
    input  carv_req, carv_we, carv_lock, carv_addr, carv_wdata, disp_req, disp_addr, mem_rdata,
    output carv_gnt, carv_rvalid, carv_rdata, disp_gnt, disp_rvalid, disp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output carv_req, carv_we, carv_lock, carv_addr, carv_wdata, disp_req, disp_addr, mem_rdata,
    input  carv_gnt, carv_rvalid, carv_rdata, disp_gnt, disp_rvalid, disp_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/maze_cell_arbiter.sv
// maze_cell_arbiter: shares one cell RAM port between the maze carver and the display reader.
module maze_cell_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int CELL_W     = 2,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input logic clk,
  input logic reset,
  maze_cell_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {ARB, LOCKED, FORCE_DISP} state_e;
  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [LW-1:0]     lock_q, lock_d, lock_inc;
  logic              carv_gnt, disp_gnt, carv_rv_q, disp_rv_q;
  logic [CELL_W-1:0] carv_hold_q, disp_hold_q;
  logic [ADDR_W-1:0] addr_sel;
  always_comb begin
    carv_gnt = 1'b0;
    disp_gnt = 1'b0;
    state_d  = state_q;
    lock_inc = (lock_q == LW'(LOCK_MAX)) ? lock_q : lock_q + 1'b1;
    if (!reset) begin
      case (state_q)
        ARB: begin
          disp_gnt = bus.disp_req && !(bus.carv_req && starve_q == SW'(STARVE_MAX));
          carv_gnt = bus.carv_req && !disp_gnt;
          if (carv_gnt && bus.carv_lock) state_d = LOCKED;
        end
        LOCKED: begin
          carv_gnt = bus.carv_req;
          if (!bus.carv_req || !bus.carv_lock) state_d = ARB;
          else if (lock_inc == LW'(LOCK_MAX) && bus.disp_req) state_d = FORCE_DISP;
        end
        FORCE_DISP: begin
          disp_gnt = bus.disp_req;
          state_d  = ARB;
        end
        default: state_d = ARB;
      endcase
    end
    // the lock count rides along the LOCKED run and is cleared whenever arbitration resumes
    lock_d   = (state_d == ARB) ? '0 : carv_gnt ? lock_inc : lock_q;
    starve_d = (!bus.carv_req || carv_gnt) ? '0 :
               (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      starve_q    <= '0;
      lock_q      <= '0;
      carv_rv_q   <= 1'b0;
      disp_rv_q   <= 1'b0;
      carv_hold_q <= '0;
      disp_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      lock_q    <= lock_d;
      carv_rv_q <= carv_gnt && !bus.carv_we;
      disp_rv_q <= disp_gnt;
      if (carv_rv_q) carv_hold_q <= bus.mem_rdata;
      if (disp_rv_q) disp_hold_q <= bus.mem_rdata;
    end
  end
  assign addr_sel        = carv_gnt ? bus.carv_addr : disp_gnt ? bus.disp_addr : '0;
  assign bus.carv_gnt    = carv_gnt;
  assign bus.disp_gnt    = disp_gnt;
  assign bus.mem_en      = carv_gnt || disp_gnt;
  assign bus.mem_we      = carv_gnt && bus.carv_we;
  assign bus.mem_addr    = addr_sel;
  assign bus.mem_wdata   = carv_gnt ? bus.carv_wdata : '0;
  assign bus.carv_rvalid = carv_rv_q && !reset;
  assign bus.disp_rvalid = disp_rv_q && !reset;
  assign bus.carv_rdata  = reset ? '0 : carv_rv_q ? bus.mem_rdata : carv_hold_q;
  assign bus.disp_rdata  = reset ? '0 : disp_rv_q ? bus.mem_rdata : disp_hold_q;
endmodule

// File: tb/tb_maze_cell_arbiter.sv
// tb_maze_cell_arbiter: directed checks of grants, read return, starvation, lock and reset behaviour.
module tb_maze_cell_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [1:0] ram [0:8191];
  maze_cell_arbiter_if #(.ADDR_W(13), .CELL_W(2)) bus ();
  maze_cell_arbiter #(.ADDR_W(13), .CELL_W(2), .STARVE_MAX(4), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic cr, input logic cw, input logic cl, input logic [12:0] ca,
                       input logic [1:0] cd, input logic dr, input logic [12:0] da);
    bus.carv_req = cr; bus.carv_we = cw; bus.carv_lock = cl; bus.carv_addr = ca;
    bus.carv_wdata = cd; bus.disp_req = dr; bus.disp_addr = da;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 2'd0;
    bus.mem_rdata = 2'd0;
    reset = 1'b1;
    drive(1, 0, 0, 5, 0, 1, 9);
    @(negedge clk);
    chk("rst_cgnt", bus.carv_gnt, 0);
    chk("rst_dgnt", bus.disp_gnt, 0);
    chk("rst_en", bus.mem_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_crv", bus.carv_rvalid, 0);
    chk("rst_drdata", bus.disp_rdata, 0);
    tick();
    reset = 1'b0;
    drive(1, 1, 0, 130, 1, 0, 0);
    @(negedge clk);
    chk("wr_gnt", bus.carv_gnt, 1);
    chk("wr_en", bus.mem_en, 1);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_addr", bus.mem_addr, 130);
    chk("wr_wdata", bus.mem_wdata, 1);
    chk("wr_dgnt", bus.disp_gnt, 0);
    tick();
    drive(1, 1, 0, 9, 3, 0, 0);
    @(negedge clk);
    chk("wr_no_rvalid", bus.carv_rvalid, 0);
    tick();
    drive(1, 0, 0, 5, 0, 1, 9);
    @(negedge clk);
    chk("both_dgnt", bus.disp_gnt, 1);
    chk("both_cgnt", bus.carv_gnt, 0);
    chk("both_addr", bus.mem_addr, 9);
    chk("both_we", bus.mem_we, 0);
    tick();
    drive(1, 0, 0, 5, 0, 0, 0);
    @(negedge clk);
    chk("both_drv", bus.disp_rvalid, 1);
    chk("both_drdata", bus.disp_rdata, 3);
    chk("both_crv", bus.carv_rvalid, 0);
    chk("held_cgnt", bus.carv_gnt, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd5_crv", bus.carv_rvalid, 1);
    chk("rd5_crdata", bus.carv_rdata, 0);
    chk("rd5_drv", bus.disp_rvalid, 0);
    chk("hold_drdata", bus.disp_rdata, 3);
    tick();
    drive(1, 0, 0, 130, 0, 1, 9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("starve_dgnt", bus.disp_gnt, 1);
      chk("starve_cgnt", bus.carv_gnt, 0);
      tick();
    end
    @(negedge clk);
    chk("forced_cgnt", bus.carv_gnt, 1);
    chk("forced_dgnt", bus.disp_gnt, 0);
    chk("forced_addr", bus.mem_addr, 130);
    tick();
    drive(0, 0, 0, 0, 0, 1, 9);
    @(negedge clk);
    chk("after_dgnt", bus.disp_gnt, 1);
    chk("after_crv", bus.carv_rvalid, 1);
    chk("after_crdata", bus.carv_rdata, 1);
    chk("after_drv", bus.disp_rvalid, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("after2_drv", bus.disp_rvalid, 1);
    chk("after2_drdata", bus.disp_rdata, 3);
    chk("hold_crdata", bus.carv_rdata, 1);
    tick();
    drive(1, 1, 1, 200, 2, 0, 0);
    @(negedge clk);
    chk("lock_c0", bus.carv_gnt, 1);
    tick();
    drive(1, 1, 1, 200, 2, 1, 9);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("lock_cgnt", bus.carv_gnt, 1);
      chk("lock_dgnt", bus.disp_gnt, 0);
      tick();
    end
    @(negedge clk);
    chk("force_dgnt", bus.disp_gnt, 1);
    chk("force_cgnt", bus.carv_gnt, 0);
    chk("force_addr", bus.mem_addr, 9);
    tick();
    @(negedge clk);
    chk("post_dgnt", bus.disp_gnt, 1);
    chk("post_cgnt", bus.carv_gnt, 0);
    chk("post_drv", bus.disp_rvalid, 1);
    chk("post_crv", bus.carv_rvalid, 0);
    tick();
    idle();
    drive(1, 0, 1, 130, 0, 0, 0);
    @(negedge clk);
    chk("ul_c0", bus.carv_gnt, 1);
    tick();
    drive(1, 0, 0, 130, 0, 1, 9);
    @(negedge clk);
    chk("ul_c1_cgnt", bus.carv_gnt, 1);
    chk("ul_c1_dgnt", bus.disp_gnt, 0);
    tick();
    @(negedge clk);
    chk("ul_c2_dgnt", bus.disp_gnt, 1);
    chk("ul_c2_cgnt", bus.carv_gnt, 0);
    tick();
    idle();
    drive(1, 0, 1, 130, 0, 0, 0);
    @(negedge clk);
    chk("rl_cgnt", bus.carv_gnt, 1);
    tick();
    reset = 1'b1;
    drive(1, 0, 1, 130, 0, 1, 9);
    @(negedge clk);
    chk("rl_rst_crv", bus.carv_rvalid, 0);
    chk("rl_rst_crdata", bus.carv_rdata, 0);
    chk("rl_rst_cgnt", bus.carv_gnt, 0);
    chk("rl_rst_dgnt", bus.disp_gnt, 0);
    chk("rl_rst_en", bus.mem_en, 0);
    chk("rl_rst_addr", bus.mem_addr, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rl_arb_dgnt", bus.disp_gnt, 1);
    chk("rl_arb_cgnt", bus.carv_gnt, 0);
    chk("rl_arb_crv", bus.carv_rvalid, 0);
    tick();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
